// File: rtl/ad5205_ctrl.sv
// AD5205 six-channel digipot controller: per-channel wiper shadows, single-channel
// writes from a register-bus requester, shadow replay, and an 11-bit 3-wire SPI master.
//
// state  | meaning
// IDLE   | arbitrate: command first, then the next pending refresh frame
// SETUP  | ssn low, sck low, first data bit settling for one half-period
// SCK_HI | sck high; device samples sdi on the rising edge
// SCK_LO | sck low; sdi moves to the next bit on entry (held after the last bit)
// GAP    | ssn high for one half-period before the next frame may start
module ad5205_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       mclk,
    input  logic       reset_n,
    input  logic       cmd_req,
    input  logic [2:0] cmd_chan,
    input  logic [7:0] cmd_pos,
    output logic       cmd_ack,
    output logic       cmd_err,
    input  logic       refresh_req,
    input  logic [2:0] rd_chan,
    output logic [7:0] rd_pos,
    output logic       busy,
    output logic       spi_sck,
    output logic       spi_sdi,
    output logic       spi_ssn
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        GAP
    } state_t;

    localparam logic [7:0] HALF_LOAD = 8'(CLK_DIV - 1);
    localparam logic [3:0] LAST_BIT  = 4'd10;
    localparam logic [2:0] LAST_CHAN = 3'd5;

    state_t      state, state_nxt;
    logic [7:0]  half_cnt, half_nxt;
    logic [3:0]  bit_cnt, bit_nxt;
    logic [10:0] shreg, shreg_nxt;
    logic        sck_nxt, ssn_nxt;
    logic        ack_nxt, err_nxt;
    logic        pending, pending_nxt;
    logic [2:0]  ref_idx, ref_nxt;
    logic [7:0]  shadow [6];
    logic        sh_we;
    logic        start;
    logic [10:0] frame;
    logic        half_done;

    assign half_done = (half_cnt == 8'd0);
    // The shift register MSB is the data line, so sdi only moves when the register moves.
    assign spi_sdi   = shreg[10];
    assign busy      = (state != IDLE) | pending;
    assign rd_pos    = (rd_chan <= LAST_CHAN) ? shadow[rd_chan] : 8'h00;

    always_comb begin
        state_nxt   = state;
        half_nxt    = half_cnt;
        bit_nxt     = bit_cnt;
        shreg_nxt   = shreg;
        sck_nxt     = spi_sck;
        ssn_nxt     = spi_ssn;
        ack_nxt     = 1'b0;
        err_nxt     = 1'b0;
        pending_nxt = pending;
        ref_nxt     = ref_idx;
        sh_we       = 1'b0;
        start       = 1'b0;
        frame       = 11'd0;

        if (refresh_req && !pending) begin
            pending_nxt = 1'b1;
            ref_nxt     = 3'd0;
        end

        if (state != IDLE) begin
            half_nxt = half_done ? HALF_LOAD : half_cnt - 8'd1;
        end

        case (state)
            IDLE: begin
                // Skipping the ack cycle keeps a still-held request from being taken twice.
                if (cmd_req && !cmd_ack) begin
                    ack_nxt = 1'b1;
                    if (cmd_chan <= LAST_CHAN) begin
                        sh_we = 1'b1;
                        start = 1'b1;
                        frame = {cmd_chan, cmd_pos};
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (pending) begin
                    start = 1'b1;
                    frame = {ref_idx, shadow[ref_idx]};
                    if (ref_idx == LAST_CHAN) begin
                        pending_nxt = 1'b0;
                        ref_nxt     = 3'd0;
                    end else begin
                        ref_nxt = ref_idx + 3'd1;
                    end
                end
            end
            SETUP: begin
                if (half_done) begin
                    sck_nxt   = 1'b1;
                    state_nxt = SCK_HI;
                end
            end
            SCK_HI: begin
                if (half_done) begin
                    sck_nxt   = 1'b0;
                    state_nxt = SCK_LO;
                    if (bit_cnt != LAST_BIT) begin
                        shreg_nxt = {shreg[9:0], 1'b0};
                    end
                end
            end
            SCK_LO: begin
                if (half_done) begin
                    if (bit_cnt == LAST_BIT) begin
                        ssn_nxt   = 1'b1;
                        state_nxt = GAP;
                    end else begin
                        bit_nxt   = bit_cnt + 4'd1;
                        sck_nxt   = 1'b1;
                        state_nxt = SCK_HI;
                    end
                end
            end
            GAP: begin
                if (half_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (start) begin
            shreg_nxt = frame;
            ssn_nxt   = 1'b0;
            sck_nxt   = 1'b0;
            bit_nxt   = 4'd0;
            half_nxt  = HALF_LOAD;
            state_nxt = SETUP;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            half_cnt <= 8'd0;
            bit_cnt  <= 4'd0;
            shreg    <= 11'd0;
            spi_sck  <= 1'b0;
            spi_ssn  <= 1'b1;
            cmd_ack  <= 1'b0;
            cmd_err  <= 1'b0;
            pending  <= 1'b0;
            ref_idx  <= 3'd0;
            for (int i = 0; i < 6; i++) begin
                shadow[i] <= 8'h80;
            end
        end else begin
            state    <= state_nxt;
            half_cnt <= half_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            spi_sck  <= sck_nxt;
            spi_ssn  <= ssn_nxt;
            cmd_ack  <= ack_nxt;
            cmd_err  <= err_nxt;
            pending  <= pending_nxt;
            ref_idx  <= ref_nxt;
            if (sh_we) begin
                shadow[cmd_chan] <= cmd_pos;
            end
        end
    end

endmodule

// File: doc/ad5205_ctrl.md
# ad5205_ctrl

SPI master and write sequencer for the AD5205 six-channel digital potentiometer. It accepts single-channel write commands from a register-bus requester and keeps a per-channel shadow copy of each wiper position. It can also replay all six shadows to the device on request, for example after a device power cycle. It drives the 3-wire (sck/sdi/ssn) interface that the AD5205 bus-functional model consumes, using 11-bit frames {chan[2:0], pos[7:0]} sent MSB first.

## Interface
- CLK_DIV, 4, SCK half-period in mclk cycles (legal 1..255)
- mclk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- cmd_req  input  1  write request, level; held until cmd_ack
- cmd_chan  input  3  target channel, legal 0..5
- cmd_pos  input  8  wiper position
- cmd_ack  output  1  one-cycle pulse: command accepted (or rejected)
- cmd_err  output  1  one-cycle pulse coincident with cmd_ack when cmd_chan > 5
- refresh_req  input  1  one-cycle pulse: replay shadows of channels 0..5
- rd_chan  input  3  shadow readback select
- rd_pos  output  8  shadow[rd_chan], combinational; 8'h00 for rd_chan > 5
- busy  output  1  frame or refresh in progress
- spi_sck  output  1  SPI clock, idle low (CPOL=0)
- spi_sdi  output  1  SPI data, changes only while sck low
- spi_ssn  output  1  chip select, active low; rising edge latches the frame in the device

## Operation
- Reset values: spi_ssn=1, spi_sck=0, spi_sdi=0, cmd_ack=0, cmd_err=0, busy=0, all shadows=8'h80 (device mid-scale), refresh pending=0.
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, GAP. There is a half-period counter (8 bit), a bit counter (0..10) and an 11-bit shift register.
- IDLE arbitration, checked at every clock edge in IDLE:
  - cmd_req has priority over pending refresh.
  - Accepted command: cmd_ack=1 for one cycle. If cmd_chan ≤ 5, shadow[cmd_chan] is written with cmd_pos and a frame starts. If cmd_chan > 5, cmd_err=1 also pulses, no frame is sent and the FSM stays in IDLE.
  - Refresh with no cmd_req: send a frame for refresh index r (0..5) using shadow[r], then increment r. Pending clears after r=5 is sent.
  - Commands accepted between refresh frames are interleaved. The refresh resumes at the next r afterwards.
- refresh_req while a refresh is pending is ignored (no restart). refresh_req and cmd_req in the same cycle: the command goes first, then the refresh.
- Frame start: the shift register loads {chan,pos}, spi_ssn→0, spi_sdi=bit10, next state SETUP.
- SETUP: CLK_DIV cycles with sck=0, then SCK_HI.
- SCK_HI: sck=1 for CLK_DIV cycles. The device samples on the rising edge. At the end:
  - bit counter < 10: go to SCK_LO, shift, spi_sdi=next bit.
  - last bit: go to SCK_LO as the hold phase; spi_sdi is held.
- SCK_LO: sck=0 for CLK_DIV cycles, then SCK_HI, or GAP after the last bit. Entry to GAP sets spi_ssn=1.
- GAP: spi_ssn=1 for CLK_DIV cycles, then IDLE. busy drops on entry to IDLE.
- busy = (state != IDLE) | refresh pending.
- Asynchronous reset mid-frame forces spi_ssn high immediately. The device may latch a partial frame. Software must issue a refresh after reset; the shadows are mid-scale at that point.
- Shadow writes occur only on command acceptance. A refresh never modifies the shadows.

## Timing
- Let N = CLK_DIV.
- cmd_ack is asserted in the cycle after the edge that samples cmd_req high in IDLE. spi_ssn falls in that same cycle.
- spi_ssn is low for exactly 23N cycles: N setup, plus 11 high phases of N, plus 11 low phases of N.
- busy is high for 24N cycles per frame. The next frame's ssn fall is no earlier than 24N cycles after the previous one.
- Each spi_sdi change occurs N cycles before the next sck rise and coincides with an sck fall or with the ssn fall.
- A full refresh with no interleaved commands takes 6×24N cycles, plus one IDLE decision cycle per frame.
- cmd_req held high: at most one ack per frame. The requester drops or changes cmd_req after ack.

## Test plan
- Reset, then read rd_chan 0..5 → rd_pos=8'h80 each; spi_ssn=1, spi_sck=0, busy=0.
- N=4, command chan=3 pos=8'hA5 → the BFM shows channel=3 and position=8'hA5 after ssn rises; ssn low 92 cycles; 11 sck rises; rd_pos[3]=8'hA5.
- Command chan=6 → cmd_ack and cmd_err pulse together; no ssn activity; shadows unchanged.
- Write ch0=8'h11 and ch5=8'hEE, then refresh_req → six frames in order ch0..ch5 with values 11,80,80,80,80,EE; the BFM's final state is channel=5, position=8'hEE.
- During refresh frame r=2, issue command chan=1 pos=8'h7F → the order of frames is 2, then cmd(1,7F), then 3, 4, 5; refresh values come from the shadows as they stand when each frame is sent.
- Assert reset_n low mid-SCK_HI of bit 5 → ssn=1 and sck=0 immediately; after release, busy=0 and shadows=8'h80.
